// File: rtl/prog_loader_pkg.sv
// Shared encodings for the program loader: loader/receiver state values and default bit timing.
package prog_loader_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 104;

    typedef enum logic [2:0] {
        ST_WAIT_LEN = 3'd0,
        ST_LOAD     = 3'd1,
        ST_CHECK    = 3'd2,
        ST_RUN      = 3'd3,
        ST_ERROR    = 3'd4
    } ld_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/prog_loader_uart_rx.sv
// 8N1 UART receiver with 2-flop synchronizer; rx_valid/rx_frame_err pulse 1 cycle after the stop-bit centre.
// No backpressure: each byte is presented for exactly one cycle.
module uart_rx
    import prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);

    rx_state_e     r_state;
    rx_state_e     w_state_nxt;
    logic [1:0]    r_sync;
    logic          r_rx_d;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_shift;
    logic          r_valid;
    logic          r_ferr;
    logic          w_rx;
    logic          w_half;
    logic          w_full;
    logic          w_cnt_clr;
    logic          w_sample;
    logic          w_stop_sample;

    assign w_rx   = r_sync[1];
    assign w_half = (r_cnt == CW'(CLKS_PER_BIT / 2 - 1));
    assign w_full = (r_cnt == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_clr     = 1'b0;
        w_sample      = 1'b0;
        w_stop_sample = 1'b0;
        case (r_state)
            RX_IDLE: begin
                if (r_rx_d && !w_rx) begin
                    w_state_nxt = RX_START;
                    w_cnt_clr   = 1'b1;
                end
            end
            RX_START: begin
                // Line back high at mid-start means a glitch, not a frame.
                if (w_half) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = w_rx ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (w_full) begin
                    w_cnt_clr = 1'b1;
                    w_sample  = 1'b1;
                    if (r_bitcnt == 3'd7) w_state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (w_full) begin
                    w_stop_sample = 1'b1;
                    w_state_nxt   = RX_IDLE;
                end
            end
            default: w_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= RX_IDLE;
            r_sync   <= 2'b11;
            r_rx_d   <= 1'b1;
            r_cnt    <= '0;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_valid  <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sync   <= {r_sync[0], rx};
            r_rx_d   <= w_rx;
            r_cnt    <= w_cnt_clr ? '0 : r_cnt + 1'b1;
            if (r_state == RX_START) r_bitcnt <= '0;
            else if (w_sample)       r_bitcnt <= r_bitcnt + 1'b1;
            if (w_sample) r_shift <= {w_rx, r_shift[7:1]};
            r_valid  <= w_stop_sample & w_rx;
            r_ferr   <= w_stop_sample & ~w_rx;
        end
    end

    assign rx_data      = r_shift;
    assign rx_valid     = r_valid;
    assign rx_frame_err = r_ferr;

endmodule

// File: rtl/prog_loader.sv
// Loads a length-prefixed UART image into RAM, then releases the CPU; PROG_LOADER_CHECKSUM_EN adds a trailing checksum.
// RAM write 1 cycle after each byte-valid; no backpressure, the RAM must take every strobe.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int ADDR_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic              wr_enable,
    output logic [ADDR_W-1:0] addr_bus,
    output logic [7:0]        wdata,
    output logic              cpu_run,
    output logic              busy,
    output logic              err
);

    localparam logic [ADDR_W:0] FULL_LEN = (ADDR_W + 1)'(256);

    ld_state_e         r_state;
    ld_state_e         w_state_nxt;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_addr;
    logic [ADDR_W-1:0] r_addr_out;
    logic [7:0]        r_wdata;
    logic              r_wr_en;
    logic [ADDR_W:0]   w_addr_inc;
    logic              w_last;
    logic              w_latch_len;
    logic              w_write;
    logic [7:0]        w_rx_data;
    logic              w_rx_valid;
    logic              w_rx_ferr;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]        r_sum;
`endif

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_rx (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .rx_data      (w_rx_data),
        .rx_valid     (w_rx_valid),
        .rx_frame_err (w_rx_ferr)
    );

    assign w_addr_inc = r_addr + 1'b1;
    assign w_last     = (w_addr_inc == r_len);

    always_comb begin
        w_state_nxt = r_state;
        w_latch_len = 1'b0;
        w_write     = 1'b0;
        case (r_state)
            ST_WAIT_LEN: begin
                if (w_rx_valid) begin
                    w_latch_len = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_rx_ferr) begin
                    w_state_nxt = ST_ERROR;
                end else if (w_rx_valid) begin
                    w_write = 1'b1;
                end else if (r_wr_en && w_last) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    w_state_nxt = ST_CHECK;
`else
                    w_state_nxt = ST_RUN;
`endif
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (w_rx_ferr)       w_state_nxt = ST_ERROR;
                else if (w_rx_valid) w_state_nxt = (w_rx_data == r_sum) ? ST_RUN : ST_ERROR;
            end
`endif
            ST_RUN:   w_state_nxt = ST_RUN;
            ST_ERROR: w_state_nxt = ST_ERROR;
            default:  w_state_nxt = ST_WAIT_LEN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_WAIT_LEN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The strobed address is captured separately so the bus holds the last written address in RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len      <= '0;
            r_addr     <= '0;
            r_addr_out <= '0;
            r_wdata    <= '0;
            r_wr_en    <= 1'b0;
        end else begin
            r_wr_en <= w_write;
            if (w_latch_len) begin
                r_len  <= (w_rx_data == 8'd0) ? FULL_LEN : (ADDR_W + 1)'(w_rx_data);
                r_addr <= '0;
            end else if (r_wr_en) begin
                r_addr <= w_addr_inc;
            end
            if (w_write) begin
                r_wdata    <= w_rx_data;
                r_addr_out <= r_addr[ADDR_W-1:0];
            end
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
        end else if (w_latch_len) begin
            r_sum <= '0;
        end else if (w_write) begin
            r_sum <= r_sum + w_rx_data;
        end
    end
`endif

    assign wr_enable = r_wr_en;
    assign addr_bus  = r_addr_out;
    assign wdata     = r_wdata;
    assign busy      = (r_state == ST_LOAD) || (r_state == ST_CHECK);
    assign cpu_run   = (r_state == ST_RUN);
    assign err       = (r_state == ST_ERROR);

endmodule
